// File: rtl/qspi_read_ctrl_if.sv
// Host request/response and QSPI pad signals of the quad-read sequencer.
// No storage or added latency; this only groups wires.
// There is no backpressure: requests are ignored while busy=1.
interface qspi_read_ctrl_if;
    // host side
    logic        req;
    logic [23:0] addr;
    logic [7:0]  len;
    logic        busy;
    logic [7:0]  rdata;
    logic        rvalid;
    logic        done;
    // pad side
    logic        spi_sck;
    logic        spi_csn;
    logic [3:0]  spi_sio_o;
    logic [3:0]  spi_sio_oe;
    logic [3:0]  spi_sio_i;

    // fabric / bench view: drives requests and the pad inputs
    modport master (
        output req, addr, len, spi_sio_i,
        input  busy, rdata, rvalid, done, spi_sck, spi_csn, spi_sio_o, spi_sio_oe
    );

    // controller view
    modport slave (
        input  req, addr, len, spi_sio_i,
        output busy, rdata, rvalid, done, spi_sck, spi_csn, spi_sio_o, spi_sio_oe
    );
endinterface

// File: rtl/qspi_read_ctrl.sv
// Quad-SPI Fast Read Quad I/O sequencer: command, 24-bit address, dummy cells, then N bytes.
// Latency: CSN falls on the accept edge; each byte appears one edge after its low nibble is sampled.
// No backpressure: rvalid is a one-cycle strobe; req is ignored while busy=1 (no queue).
module qspi_read_ctrl #(
    parameter int          CLK_DIV   = 2,
    parameter int          DUMMY_CYC = 6,
    parameter int          CS_HIGH   = 4,
    parameter logic [7:0]  CMD       = 8'hEB
) (
    input  logic              sys_clk,
    input  logic              reset_n,
    qspi_read_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_ADDR  = 3'd2,
        S_DUMMY = 3'd3,
        S_DATA  = 3'd4,
        S_HOLD  = 3'd5
    } state_t;

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HOLD_W = (CS_HIGH > 1) ? $clog2(CS_HIGH) : 1;

    // sequencing state
    state_t              r_state,    w_state;
    logic [DIV_W-1:0]    r_div,      w_div;
    logic                r_phase,    w_phase;     // 0 = SCK low phase, 1 = high phase
    logic [7:0]          r_cell,     w_cell;      // cell index inside the current state
    logic [23:0]         r_shift,    w_shift;     // address, shifted out a nibble per cell
    logic [8:0]          r_bytes,    w_bytes;     // bytes still to read (1..256)
    logic [3:0]          r_nib,      w_nib;       // high nibble of the byte in flight
    logic [7:0]          r_byte,     w_byte;      // assembled byte waiting for the strobe
    logic                r_byte_rdy, w_byte_rdy;
    logic [HOLD_W-1:0]   r_hold,     w_hold;

    // registered outputs
    logic                r_busy,     w_busy;
    logic [7:0]          r_rdata,    w_rdata;
    logic                r_rvalid,   w_rvalid;
    logic                r_done,     w_done;
    logic                r_sck,      w_sck;
    logic                r_csn,      w_csn;
    logic [3:0]          r_sio_o,    w_sio_o;
    logic [3:0]          r_sio_oe,   w_sio_oe;

    logic                w_div_end;
    logic                w_cell_end;
    logic [2:0]          w_cmd_idx;

    assign w_div_end  = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_cell_end = w_div_end && r_phase;
    // command bit presented in the cell following the current one
    assign w_cmd_idx  = 3'd6 - r_cell[2:0];

    // next-state and next-output logic; pad values change only at cell boundaries
    always_comb begin
        w_state    = r_state;
        w_div      = r_div;
        w_phase    = r_phase;
        w_cell     = r_cell;
        w_shift    = r_shift;
        w_bytes    = r_bytes;
        w_nib      = r_nib;
        w_byte     = r_byte;
        w_byte_rdy = 1'b0;
        w_hold     = r_hold;
        w_busy     = r_busy;
        w_rvalid   = r_byte_rdy;
        w_rdata    = r_byte_rdy ? r_byte : r_rdata;
        w_done     = 1'b0;
        w_sck      = r_sck;
        w_csn      = r_csn;
        w_sio_o    = r_sio_o;
        w_sio_oe   = r_sio_oe;

        case (r_state)
            S_IDLE: begin
                if (bus.req) begin
                    // CSN falls and the first low phase starts right away,
                    // so CS setup equals one low phase
                    w_state  = S_CMD;
                    w_shift  = bus.addr;
                    w_bytes  = (bus.len == 8'd0) ? 9'd256 : {1'b0, bus.len};
                    w_div    = '0;
                    w_phase  = 1'b0;
                    w_cell   = 8'd0;
                    w_busy   = 1'b1;
                    w_csn    = 1'b0;
                    w_sck    = 1'b0;
                    w_sio_oe = 4'b0001;
                    w_sio_o  = {3'b000, CMD[7]};
                end
            end

            S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
                if (!w_div_end) begin
                    w_div = r_div + DIV_W'(1);
                end else begin
                    w_div = '0;
                    if (!r_phase) begin
                        w_phase = 1'b1;
                        w_sck   = 1'b1;
                    end else begin
                        // end of a high phase: SCK falls, input is sampled,
                        // and the next cell's output is launched
                        w_phase = 1'b0;
                        w_sck   = 1'b0;
                        w_cell  = r_cell + 8'd1;
                        case (r_state)
                            S_CMD: begin
                                if (r_cell == 8'd7) begin
                                    w_state  = S_ADDR;
                                    w_cell   = 8'd0;
                                    w_sio_oe = 4'b1111;
                                    w_sio_o  = r_shift[23:20];
                                end else begin
                                    w_sio_o  = {3'b000, CMD[w_cmd_idx]};
                                end
                            end
                            S_ADDR: begin
                                if (r_cell == 8'd5) begin
                                    // mode bits 0x00 on all four lanes
                                    w_state = S_DUMMY;
                                    w_cell  = 8'd0;
                                    w_sio_o = 4'b0000;
                                end else begin
                                    w_shift = r_shift << 4;
                                    w_sio_o = r_shift[19:16];
                                end
                            end
                            S_DUMMY: begin
                                w_sio_o = 4'b0000;
                                if (r_cell == 8'(DUMMY_CYC - 1)) begin
                                    w_state  = S_DATA;
                                    w_cell   = 8'd0;
                                    w_sio_oe = 4'b0000;
                                end else begin
                                    // only the two mode-bit cells are driven
                                    w_sio_oe = (r_cell == 8'd0) ? 4'b1111 : 4'b0000;
                                end
                            end
                            S_DATA: begin
                                if (r_cell == 8'd0) begin
                                    w_nib = bus.spi_sio_i;
                                end else begin
                                    w_cell     = 8'd0;
                                    w_byte     = {r_nib, bus.spi_sio_i};
                                    w_byte_rdy = 1'b1;
                                    w_bytes    = r_bytes - 9'd1;
                                    if (r_bytes == 9'd1) begin
                                        // CSN rises together with the last SCK fall
                                        w_state = S_HOLD;
                                        w_csn   = 1'b1;
                                        w_hold  = '0;
                                        w_done  = (CS_HIGH == 1);
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end

            S_HOLD: begin
                if (r_hold == HOLD_W'(CS_HIGH - 1)) begin
                    w_state = S_IDLE;
                    w_busy  = 1'b0;
                end else begin
                    w_hold = r_hold + HOLD_W'(1);
                    w_done = ((int'(r_hold) + 1) == (CS_HIGH - 1));
                end
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // state and output registers; reset aborts any transaction without a done pulse
    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_phase    <= 1'b0;
            r_cell     <= 8'd0;
            r_shift    <= 24'd0;
            r_bytes    <= 9'd0;
            r_nib      <= 4'd0;
            r_byte     <= 8'd0;
            r_byte_rdy <= 1'b0;
            r_hold     <= '0;
            r_busy     <= 1'b0;
            r_rdata    <= 8'd0;
            r_rvalid   <= 1'b0;
            r_done     <= 1'b0;
            r_sck      <= 1'b0;
            r_csn      <= 1'b1;
            r_sio_o    <= 4'd0;
            r_sio_oe   <= 4'd0;
        end else begin
            r_state    <= w_state;
            r_div      <= w_div;
            r_phase    <= w_phase;
            r_cell     <= w_cell;
            r_shift    <= w_shift;
            r_bytes    <= w_bytes;
            r_nib      <= w_nib;
            r_byte     <= w_byte;
            r_byte_rdy <= w_byte_rdy;
            r_hold     <= w_hold;
            r_busy     <= w_busy;
            r_rdata    <= w_rdata;
            r_rvalid   <= w_rvalid;
            r_done     <= w_done;
            r_sck      <= w_sck;
            r_csn      <= w_csn;
            r_sio_o    <= w_sio_o;
            r_sio_oe   <= w_sio_oe;
        end
    end

    assign bus.busy       = r_busy;
    assign bus.rdata      = r_rdata;
    assign bus.rvalid     = r_rvalid;
    assign bus.done       = r_done;
    assign bus.spi_sck    = r_sck;
    assign bus.spi_csn    = r_csn;
    assign bus.spi_sio_o  = r_sio_o;
    assign bus.spi_sio_oe = r_sio_oe;

endmodule

// File: tb/tb_qspi_read_ctrl.sv
// Bench for qspi_read_ctrl: behavioural flash model on the pads plus per-scenario checks.
// Expected data comes from a byte array addressed by the captured flash address.
// Pad discipline is watched continuously and checked at the end.
module tb_qspi_read_ctrl;

    localparam int         CLK_DIV   = 2;
    localparam int         DUMMY_CYC = 6;
    localparam int         CS_HIGH   = 4;
    localparam logic [7:0] CMD       = 8'hEB;

    logic sys_clk = 1'b0;
    logic reset_n = 1'b0;

    qspi_read_ctrl_if bus ();

    qspi_read_ctrl #(
        .CLK_DIV   (CLK_DIV),
        .DUMMY_CYC (DUMMY_CYC),
        .CS_HIGH   (CS_HIGH),
        .CMD       (CMD)
    ) dut (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_err = 0;

    // flash contents; the model flash wraps at 1 KiB
    logic [7:0] mem [0:1023];

    // pad monitor / flash model state
    bit          armed = 1'b0;
    logic        p_sck, p_csn;
    logic [3:0]  p_oe;
    int          rise = 0;
    logic [7:0]  mon_cmd;
    logic [23:0] mon_addr;
    int          pad_viol = 0;
    logic [7:0]  rx_q [$];
    int          done_cnt = 0;
    int          csn_falls = 0;
    int          last_rise_n = 0;
    logic [23:0] last_addr;
    logic [7:0]  last_cmd;

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        return mem[a[9:0]];
    endfunction

    // flash model and pad discipline watcher, sampled mid-cycle
    always @(negedge sys_clk) begin
        logic [3:0] exp_oe;
        logic [7:0] b;
        int j;
        if (armed) begin
            if (bus.rvalid === 1'b1) rx_q.push_back(bus.rdata);
            if (bus.done === 1'b1) done_cnt++;
            if (bus.spi_csn === 1'b1 && bus.spi_sck !== 1'b0) pad_viol++;
            if (bus.spi_sck !== p_sck && p_csn !== 1'b0) pad_viol++;
            if (bus.spi_sio_oe !== p_oe && bus.spi_sck !== 1'b0) pad_viol++;
            if (p_csn === 1'b1 && bus.spi_csn === 1'b0) begin
                rise = 0;
                csn_falls++;
            end
            if (bus.spi_csn === 1'b0 && p_sck === 1'b0 && bus.spi_sck === 1'b1) begin
                rise++;
                exp_oe = (rise <= 8) ? 4'b0001 : ((rise <= 16) ? 4'b1111 : 4'b0000);
                if (bus.spi_sio_oe !== exp_oe) pad_viol++;
                if (rise <= 8) begin
                    mon_cmd = {mon_cmd[6:0], bus.spi_sio_o[0]};
                    if (bus.spi_sio_o[3:1] !== 3'b000) pad_viol++;
                end else if (rise <= 14) begin
                    mon_addr = {mon_addr[19:0], bus.spi_sio_o};
                end else if (rise <= 16) begin
                    if (bus.spi_sio_o !== 4'b0000) pad_viol++;
                end
                if (rise > 14 + DUMMY_CYC) begin
                    j = rise - 15 - DUMMY_CYC;
                    b = flash_byte(mon_addr + 24'(j / 2));
                    bus.spi_sio_i = (j % 2 == 0) ? b[7:4] : b[3:0];
                end else begin
                    bus.spi_sio_i = 4'($urandom);
                end
            end
            if (p_csn === 1'b0 && bus.spi_csn === 1'b1) begin
                last_rise_n = rise;
                last_addr   = mon_addr;
                last_cmd    = mon_cmd;
            end
        end else begin
            bus.spi_sio_i = 4'h0;
        end
        p_sck = bus.spi_sck;
        p_csn = bus.spi_csn;
        p_oe  = bus.spi_sio_oe;
        if (reset_n === 1'b0) armed = 1'b1;
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (bus.busy === 1'b0) break;
            tick();
        end
    endtask

    // runs until done is seen; counts cycles with CSN high while still busy
    task automatic wait_done(input int budget, output int hold, output bit ok);
        hold = 0;
        ok   = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (bus.spi_csn === 1'b1 && bus.busy === 1'b1) hold++;
            if (bus.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic int txn_budget(input int n);
        return (14 + DUMMY_CYC + 2 * n) * 2 * CLK_DIV + CS_HIGH + 20;
    endfunction

    // one complete read checked against the flash array
    task automatic do_read(input logic [23:0] a, input int n);
        int d0, f0, hold, bad, sz;
        bit got;
        rx_q.delete();
        d0 = done_cnt;
        f0 = csn_falls;
        wait_idle();
        bus.addr = a;
        bus.len  = 8'(n);
        bus.req  = 1'b1;
        tick();
        bus.req  = 1'b0;
        bus.addr = 24'($urandom);
        bus.len  = 8'($urandom);
        n_cmp++;
        if ({bus.busy, bus.spi_csn, bus.spi_sck} !== 3'b100) begin
            n_err++;
            $display("FAIL accept a=%h: busy/csn/sck=%b%b%b required 100", a, bus.busy, bus.spi_csn, bus.spi_sck);
        end
        wait_done(txn_budget(n), hold, got);
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL done_timeout a=%h n=%0d: no done within %0d cycles", a, n, txn_budget(n));
        end
        n_cmp++;
        if (hold != CS_HIGH) begin
            n_err++;
            $display("FAIL cs_hold a=%h: csn-high busy cycles %0d required %0d", a, hold, CS_HIGH);
        end
        tick();
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL busy_fall a=%h: busy=%b done=%b required 0 0", a, bus.busy, bus.done);
        end
        sz = rx_q.size();
        n_cmp++;
        if (sz != n) begin
            n_err++;
            $display("FAIL byte_count a=%h: got %0d required %0d", a, sz, n);
        end
        bad = 0;
        for (int i = 0; i < sz && i < n; i++)
            if (rx_q[i] !== flash_byte(a + 24'(i))) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL byte_data a=%h n=%0d: %0d bytes differ from flash model", a, n, bad);
        end
        n_cmp++;
        if (last_rise_n != 14 + DUMMY_CYC + 2 * n) begin
            n_err++;
            $display("FAIL sck_edges a=%h: got %0d required %0d", a, last_rise_n, 14 + DUMMY_CYC + 2 * n);
        end
        n_cmp++;
        if (last_addr !== a || last_cmd !== CMD) begin
            n_err++;
            $display("FAIL cmd_addr: got cmd=%h addr=%h required cmd=%h addr=%h", last_cmd, last_addr, CMD, a);
        end
        n_cmp++;
        if (done_cnt - d0 != 1 || csn_falls - f0 != 1) begin
            n_err++;
            $display("FAIL txn_count a=%h: done pulses %0d csn falls %0d required 1 1", a, done_cnt - d0, csn_falls - f0);
        end
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        bus.req  = 1'b1;
        bus.addr = 24'h123456;
        bus.len  = 8'd5;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({bus.spi_csn, bus.spi_sck, bus.spi_sio_oe, bus.spi_sio_o, bus.busy, bus.rvalid, bus.done, bus.rdata}
                !== {1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
                n_err++;
                $display("FAIL reset_state cyc%0d: csn=%b sck=%b oe=%h o=%h busy=%b rvalid=%b done=%b rdata=%h required 1 0 0 0 0 0 0 00",
                         i, bus.spi_csn, bus.spi_sck, bus.spi_sio_oe, bus.spi_sio_o, bus.busy, bus.rvalid, bus.done, bus.rdata);
            end
        end
        bus.req = 1'b0;
        reset_n = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (bus.spi_csn !== 1'b1 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: csn=%b busy=%b required 1 0", bus.spi_csn, bus.busy);
        end
    endtask

    task automatic test_basic();
        do_read(24'h000200, 4);
        n_cmp++;
        if (last_cmd !== 8'b1110_1011) begin
            n_err++;
            $display("FAIL cmd_bits: got %b required 11101011", last_cmd);
        end
        n_cmp++;
        if (last_addr !== 24'h000200) begin
            n_err++;
            $display("FAIL addr_nibbles: got %h required 000200", last_addr);
        end
        n_cmp++;
        if (rx_q.size() != 4 || rx_q[0] !== 8'h48 || rx_q[1] !== 8'h65 || rx_q[2] !== 8'h6C || rx_q[3] !== 8'h6C) begin
            n_err++;
            $display("FAIL hello_bytes: got %0d bytes, first %h required 48 65 6C 6C", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
        end
        n_cmp++;
        if (last_rise_n != 28) begin
            n_err++;
            $display("FAIL basic_edges: got %0d required 28", last_rise_n);
        end
    endtask

    task automatic test_len0();
        do_read(24'h000000, 256);
        n_cmp++;
        if (last_rise_n != 532) begin
            n_err++;
            $display("FAIL len0_edges: got %0d required 532", last_rise_n);
        end
        n_cmp++;
        if (rx_q.size() != 256 || rx_q[255] !== mem[255]) begin
            n_err++;
            $display("FAIL len0_last: size %0d byte255 %h required 256 %h", rx_q.size(), (rx_q.size() == 256) ? rx_q[255] : 8'hxx, mem[255]);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            repeat ($urandom_range(0, 5)) tick();
            do_read(24'($urandom), $urandom_range(1, 24));
        end
    endtask

    task automatic test_back_to_back();
        int f0, gap, hold;
        bit got, low;
        rx_q.delete();
        f0 = csn_falls;
        wait_idle();
        bus.addr = 24'h000010;
        bus.len  = 8'd3;
        bus.req  = 1'b1;
        tick();
        bus.addr = 24'h000020;
        bus.len  = 8'd2;
        wait_done(txn_budget(3), hold, got);
        n_cmp++;
        if (!got || csn_falls - f0 != 1 || last_addr !== 24'h000010 || rx_q.size() != 3) begin
            n_err++;
            $display("FAIL b2b_first: done=%b falls=%0d addr=%h bytes=%0d required 1 1 000010 3",
                     got, csn_falls - f0, last_addr, rx_q.size());
        end
        gap = hold;
        low = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.spi_csn === 1'b0) begin
                low = 1'b1;
                break;
            end
            gap++;
        end
        bus.req = 1'b0;
        n_cmp++;
        if (!low || gap < CS_HIGH + 1) begin
            n_err++;
            $display("FAIL b2b_gap: second csn low=%b after %0d high cycles required >= %0d", low, gap, CS_HIGH + 1);
        end
        wait_done(txn_budget(2), hold, got);
        tick();
        n_cmp++;
        if (!got || last_addr !== 24'h000020 || csn_falls - f0 != 2) begin
            n_err++;
            $display("FAIL b2b_second: done=%b addr=%h falls=%0d required 1 000020 2", got, last_addr, csn_falls - f0);
        end
        n_cmp++;
        if (rx_q.size() != 5 || rx_q[0] !== mem[16] || rx_q[2] !== mem[18] || rx_q[3] !== mem[32] || rx_q[4] !== mem[33]) begin
            n_err++;
            $display("FAIL b2b_data: got %0d bytes required 5 matching flash 0x10.. and 0x20..", rx_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        bit seen;
        rx_q.delete();
        wait_idle();
        bus.addr = 24'h000200;
        bus.len  = 8'd4;
        bus.req  = 1'b1;
        tick();
        bus.req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < txn_budget(4); i++) begin
            tick();
            if (rx_q.size() >= 2) begin
                seen = 1'b1;
                break;
            end
        end
        d0 = done_cnt;
        reset_n = 1'b0;
        tick();
        n_cmp++;
        if (!seen || {bus.spi_csn, bus.spi_sck, bus.spi_sio_oe, bus.busy, bus.rvalid, bus.done} !== {1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_mid: seen2=%b csn=%b sck=%b oe=%h busy=%b rvalid=%b done=%b required 1 1 0 0 0 0 0",
                     seen, bus.spi_csn, bus.spi_sck, bus.spi_sio_oe, bus.busy, bus.rvalid, bus.done);
        end
        reset_n = 1'b1;
        repeat (60) tick();
        n_cmp++;
        if (rx_q.size() != 2 || done_cnt != d0 || bus.spi_csn !== 1'b1) begin
            n_err++;
            $display("FAIL reset_quiet: bytes=%0d done pulses=%0d csn=%b required 2 0 1", rx_q.size(), done_cnt - d0, bus.spi_csn);
        end
        n_cmp++;
        if (rx_q[0] !== 8'h48 || rx_q[1] !== 8'h65) begin
            n_err++;
            $display("FAIL reset_partial_bytes: got %h %h required 48 65", rx_q[0], rx_q[1]);
        end
        do_read(24'h000200, 4);
    endtask

    task automatic test_pad_discipline();
        n_cmp++;
        if (pad_viol != 0) begin
            n_err++;
            $display("FAIL pad_discipline: %0d violations required 0", pad_viol);
        end
    endtask

    initial begin
        bus.req  = 1'b0;
        bus.addr = 24'd0;
        bus.len  = 8'd0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[10'h200] = 8'h48;
        mem[10'h201] = 8'h65;
        mem[10'h202] = 8'h6C;
        mem[10'h203] = 8'h6C;
        test_reset();
        test_basic();
        test_len0();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_pad_discipline();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/qspi_read_ctrl.md
Name: qspi_read_ctrl

Overview:
- Quad-SPI flash read sequencer: on request, issues a Fast Read Quad I/O (0xEB) transaction with a 24-bit address and returns a burst of bytes.
- Sits between the on-board fabric (hello_world top, LED/console logic) and the spi_sck/spi_csn/spi_sio pads.
- Drives SCK in SPI mode 0, generates per-lane output enables for the bidirectional sio pads, and streams read bytes out with a valid strobe.

Parameters:
- CLK_DIV, 2: sys_clk cycles per SCK half-period (≥1).
- DUMMY_CYC, 6: SCK cycles between the address and the data phase, counting the 2 mode-bit cycles (≥2).
- CS_HIGH, 4: minimum sys_clk cycles spi_csn stays high after a transaction.
- CMD, 8'hEB: command byte.

Ports:
- sys_clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- req  in  1  start request, sampled only while busy=0
- addr  in  24  flash byte address, latched on accept
- len  in  8  byte count, latched on accept; 0 means 256
- busy  out  1  transaction in progress, including the CS_HIGH hold
- rdata  out  8  read byte
- rvalid  out  1  one-cycle strobe, rdata valid
- done  out  1  one-cycle pulse at the end of the transaction
- spi_sck  out  1  serial clock, idle 0
- spi_csn  out  1  chip select, idle 1
- spi_sio_o  out  4  pad output data
- spi_sio_oe  out  4  per-lane output enable (1 = drive)
- spi_sio_i  in  4  pad input data

Behaviour:
- Reset (reset_n=0 at a sys_clk edge): busy=0, rvalid=0, done=0, rdata=0, spi_sck=0, spi_csn=1, spi_sio_o=0, spi_sio_oe=0; state=IDLE.
- Reset during a transaction takes effect at the next edge with the same values. No done pulse. No partial byte is emitted.
- All outputs are registered.
- Accept: in IDLE, req=1 at edge k latches addr/len. At k+1: busy=1, spi_csn=0, spi_sck=0.
- req is ignored while busy=1. There is no queue.
- States: IDLE → CMD → ADDR → DUMMY → DATA → HOLD → IDLE.
- SCK bit cell: a low phase of CLK_DIV cycles, then a high phase of CLK_DIV cycles.
  - Output data changes only at the start of a low phase.
  - Input is sampled at the sys_clk edge that ends the high phase (SCK 1→0).
  - The first low phase begins at k+1, with CS setup equal to one low phase.
- CMD: 8 cells, single-lane. spi_sio_oe=4'b0001; spi_sio_o[0]=CMD bit 7 down to bit 0; other lanes 0.
- ADDR: 6 cells, quad. oe=4'b1111; nibbles addr[23:20] first through addr[3:0]; sio[3] carries the MSB of each nibble.
- DUMMY: DUMMY_CYC cells.
  - First 2 cells: oe=4'b1111, o=4'b0000 (mode bits 0x00, no continuous read).
  - Remaining cells: oe=0.
- DATA: oe=0; 2 cells per byte, high nibble first.
  - rvalid pulses for 1 cycle, with rdata valid, on the edge after the second nibble is sampled.
  - Bytes are emitted in ascending address order.
- Byte counter: 9 bits, loaded with len, or 256 when len=0. Decrements per byte. DATA ends after the cell in which the count reaches 0.
- HOLD: spi_csn=1 and spi_sck=0 on the edge that ends the last high phase; oe=0. Held for CS_HIGH cycles.
  - done pulses on the last HOLD cycle.
  - busy falls on the edge after done.
  - req is first accepted on the cycle after busy falls.
- Total SCK rising edges per transaction = 14 + DUMMY_CYC + 2·N.
- spi_sck never toggles while spi_csn=1.
- spi_sio_oe switches only while spi_sck=0.
- Address wrap: no address is generated internally; the flash wraps at its own boundary.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with req=1 → spi_csn=1, spi_sck=0, oe=0, busy=0, no rvalid/done.
- Basic read (CLK_DIV=2, DUMMY_CYC=6): addr=24'h000200, len=4, flash model returns 0x48,0x65,0x6C,0x6C.
  - sio[0] over CMD = 1,1,1,0,1,0,1,1.
  - ADDR nibbles = 0,0,0,2,0,0.
  - rdata sequence = 48,65,6C,6C with exactly 4 rvalid pulses.
  - 28 SCK rising edges, then done.
- len=0: addr=0 → exactly 256 rvalid pulses and 532 SCK edges; byte 255 is the model's byte at 0xFF.
- Busy/back-to-back: req held high through a transaction with addr=0x000010, then addr=0x000020 → second CSN low no earlier than CS_HIGH+1 cycles after the first CSN rise; no req accepted while busy=1.
- Reset mid-DATA after 2 of 4 bytes → next edge spi_csn=1, oe=0, busy=0; no further rvalid, no done; a subsequent request completes normally.
- Pad discipline checker across all runs: oe never changes while SCK=1, SCK never toggles with CSN=1, oe=0 in DATA.
